calibration_sequencer: RTL and testbench

CALIBRATION_SEQUENCER -- requirements
Module: calibration_sequencer

---
 rtl/calibration_pkg.sv | 32 +++
 rtl/calibration_timeout_counter.sv | 29 ++
 rtl/calibration_sequencer.sv | 123 ++++++++++++
 tb/tb_calibration_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calibration_pkg.sv
// Shared types and constants for the LED address calibration sequencer and step FSM.
// Holds the sequencer/step state encodings and the two-colour address pattern helpers.
package calibration_pkg;

  typedef enum logic [1:0] {
    STEP_IDLE         = 2'd0,
    STEP_WAIT_FOR_CAM = 2'd1,
    STEP_CAPTURE      = 2'd2,
    STEP_LATCH        = 2'd3
  } calibration_step_state_t;

  typedef enum logic [2:0] {
    SEQ_IDLE       = 3'd0,
    SEQ_PATTERN    = 3'd1,
    SEQ_STEP_START = 3'd2,
    SEQ_STEP_WAIT  = 3'd3,
    SEQ_NEXT       = 3'd4,
    SEQ_DONE       = 3'd5,
    SEQ_ERROR      = 3'd6
  } calibration_seq_state_t;

  localparam logic [23:0] PATTERN_COLOR_0 = 24'h000000;
  localparam logic [23:0] PATTERN_COLOR_1 = 24'hFFFFFF;

  // Colour LED `led` shows while address bit `bit_sel` is being calibrated.
  function automatic logic [23:0] pattern_color(input int unsigned led, input int unsigned bit_sel);
    logic [31:0] led_bits;
    led_bits = led;
    return (bit_sel < 32 && led_bits[bit_sel[4:0]]) ? PATTERN_COLOR_1 : PATTERN_COLOR_0;
  endfunction

endpackage

// File: rtl/calibration_timeout_counter.sv
// Per-wait-state watchdog: counts enabled cycles, restarts on clear, flags TIMEOUT_CYCLES-1.
// Only instantiated when CALIBRATION_SEQUENCER_TIMEOUT_EN is defined.
module calibration_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/calibration_sequencer.sv
// Walks every LED address bit: show pattern, run one calibration step, advance; reports busy/done/error.
// Optional watchdog on wait states enabled by defining CALIBRATION_SEQUENCER_TIMEOUT_EN.
module calibration_sequencer
  import calibration_pkg::*;
#(
  parameter int unsigned LED_ADDRESS_WIDTH = 10,
  parameter int unsigned TIMEOUT_CYCLES    = 50000000
) (
  input  logic                                   clk_pixel,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic                                   led_update_ack,
  input  calibration_step_state_t                step_state,
  output logic                                   led_update_req,
  output logic [$clog2(LED_ADDRESS_WIDTH+1)-1:0] bit_index,
  output logic                                   start_calibration_step,
  output logic                                   should_overwrite_latch,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   error,
  output logic [2:0]                             seq_state
);

  localparam int unsigned BW = $clog2(LED_ADDRESS_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(LED_ADDRESS_WIDTH - 1);

  calibration_seq_state_t state, state_next;
  logic start_prev;
  logic start_armed;
  logic start_rise;
  logic last_bit;
  logic timeout_expired;

  // The first sampled cycle after reset has no valid history, so a start held through reset is not an edge.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      start_prev  <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      start_prev  <= start;
      start_armed <= 1'b1;
    end
  end

  assign start_rise = start & ~start_prev & start_armed;
  assign last_bit   = (bit_index == LAST_BIT);

`ifdef CALIBRATION_SEQUENCER_TIMEOUT_EN
  logic waiting;
  logic timeout_raw;

  assign waiting = (state == SEQ_PATTERN) || (state == SEQ_STEP_START) || (state == SEQ_STEP_WAIT);

  calibration_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk_pixel),
    .rst_n  (rst_n),
    .clear  (state_next != state),
    .enable (waiting),
    .expired(timeout_raw)
  );

  assign timeout_expired = waiting & timeout_raw;
`else
  // Watchdog absent: the parameter is kept only so instantiations stay interchangeable.
  assign timeout_expired = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEQ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = SEQ_IDLE;
    end else if (timeout_expired) begin
      state_next = SEQ_ERROR;
    end else begin
      unique case (state)
        SEQ_IDLE, SEQ_DONE, SEQ_ERROR: if (start_rise) state_next = SEQ_PATTERN;
        SEQ_PATTERN:    if (led_update_ack) state_next = SEQ_STEP_START;
        SEQ_STEP_START: if (step_state != STEP_IDLE) state_next = SEQ_STEP_WAIT;
        SEQ_STEP_WAIT:  if (step_state == STEP_IDLE) state_next = SEQ_NEXT;
        SEQ_NEXT:       state_next = last_bit ? SEQ_DONE : SEQ_PATTERN;
        default:        state_next = SEQ_IDLE;
      endcase
    end
  end

  // Entering PATTERN from NEXT advances the bit; entering from any idle-like state restarts at bit 0.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      bit_index <= '0;
    end else if (abort) begin
      bit_index <= '0;
    end else if (state_next == SEQ_PATTERN && state != SEQ_PATTERN) begin
      bit_index <= (state == SEQ_NEXT) ? bit_index + BW'(1) : '0;
    end
  end

  always_comb begin
    led_update_req         = (state == SEQ_PATTERN);
    start_calibration_step = (state == SEQ_STEP_START);
    should_overwrite_latch = ((state == SEQ_PATTERN) || (state == SEQ_STEP_START)) && (bit_index == '0);
    busy                   = (state == SEQ_PATTERN) || (state == SEQ_STEP_START) ||
                             (state == SEQ_STEP_WAIT) || (state == SEQ_NEXT);
    done                   = (state == SEQ_DONE);
`ifdef CALIBRATION_SEQUENCER_TIMEOUT_EN
    error                  = (state == SEQ_ERROR);
`else
    error                  = 1'b0;
`endif
    seq_state              = state;
  end

endmodule

// File: tb/tb_calibration_sequencer.sv
// Scoreboard bench for calibration_sequencer with a randomized LED driver and step FSM model.
module tb_calibration_sequencer;
  import calibration_pkg::*;

  localparam int unsigned W  = 3;
  localparam int unsigned TO = 64;
  localparam int unsigned BW = $clog2(W + 1);
  localparam int EV_REQ = 0, EV_STEP = 1, EV_DONE = 2, EV_ERR = 3;

  typedef struct {
    int   kind;
    int   bit_i;
    logic sol;
    logic busy;
  } ev_t;

  logic clk_pixel = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic drv_ack = 1'b0;
  logic spur_ack = 1'b0;
  logic led_update_ack;
  calibration_step_state_t step_state = STEP_IDLE;

  logic          led_update_req;
  logic [BW-1:0] bit_index;
  logic          start_calibration_step;
  logic          should_overwrite_latch;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    seq_state;

  int  vectors = 0;
  int  miscompares = 0;
  ev_t exp_q[$];
  bit  ack_en = 1'b1;
  bit  step_en = 1'b1;
  bit  spur_en = 1'b0;

  assign led_update_ack = drv_ack | spur_ack;

  calibration_sequencer #(
    .LED_ADDRESS_WIDTH(W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_pixel             (clk_pixel),
    .rst_n                 (rst_n),
    .start                 (start),
    .abort                 (abort),
    .led_update_ack        (led_update_ack),
    .step_state            (step_state),
    .led_update_req        (led_update_req),
    .bit_index             (bit_index),
    .start_calibration_step(start_calibration_step),
    .should_overwrite_latch(should_overwrite_latch),
    .busy                  (busy),
    .done                  (done),
    .error                 (error),
    .seq_state             (seq_state)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: a full run shows every bit in order, latch overwrite only for bit 0, then done.
  task automatic push_bits(input int unsigned first, input int unsigned last);
    for (int unsigned b = first; b <= last; b++) begin
      exp_q.push_back('{EV_REQ,  int'(b), (b == 0), 1'b1});
      exp_q.push_back('{EV_STEP, int'(b), (b == 0), 1'b1});
    end
  endtask

  task automatic push_run();
    push_bits(0, W - 1);
    exp_q.push_back('{EV_DONE, int'(W - 1), 1'b0, 1'b0});
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d at bit %0d, expected no event", kind, bit_index);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    check("event_bit_index", bit_index, e.bit_i);
    check("event_overwrite_latch", should_overwrite_latch, e.sol);
    check("event_busy", busy, e.busy);
  endtask

  initial begin : monitor
    logic req_q, stp_q, done_q, err_q;
    req_q = 1'b0; stp_q = 1'b0; done_q = 1'b0; err_q = 1'b0;
    forever begin
      @(posedge clk_pixel);
      #1;
      if (!rst_n) begin
        req_q = 1'b0; stp_q = 1'b0; done_q = 1'b0; err_q = 1'b0;
      end else begin
        if (led_update_req && !req_q) observe(EV_REQ);
        if (start_calibration_step && !stp_q) observe(EV_STEP);
        if (done && !done_q) observe(EV_DONE);
        if (error && !err_q) observe(EV_ERR);
        req_q = led_update_req; stp_q = start_calibration_step;
        done_q = done; err_q = error;
      end
    end
  end

  initial begin : led_driver
    forever begin
      @(negedge clk_pixel);
      if (led_update_req && ack_en) begin
        repeat ($urandom_range(0, 3)) @(negedge clk_pixel);
        if (led_update_req && ack_en) begin
          drv_ack = 1'b1;
          @(negedge clk_pixel);
          drv_ack = 1'b0;
        end
      end
    end
  end

  initial begin : spurious_ack
    forever begin
      @(negedge clk_pixel);
      spur_ack = 1'b0;
      if (spur_en && !led_update_req && $urandom_range(0, 7) == 0) spur_ack = 1'b1;
    end
  end

  initial begin : step_model
    forever begin
      @(negedge clk_pixel);
      if (start_calibration_step && step_en) begin
        repeat ($urandom_range(0, 2)) @(negedge clk_pixel);
        step_state = calibration_step_state_t'($urandom_range(1, 3));
        repeat ($urandom_range(3, 20)) @(negedge clk_pixel);
        step_state = STEP_IDLE;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1, "simulation time limit");
  end

  task automatic wait_done(input string name, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk_pixel);
      n++;
    end
    check({name, "_reached_done"}, done, 1);
  endtask

  task automatic run_once();
    push_run();
    @(negedge clk_pixel);
    start = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clk_pixel);
    start = 1'b0;
    if ($urandom_range(0, 1) == 1) begin
      repeat ($urandom_range(3, 40)) @(negedge clk_pixel);
      @(negedge clk_pixel);
      if (busy) begin
        start = 1'b1;
        @(negedge clk_pixel);
        start = 1'b0;
      end
    end
    wait_done("run", 2000);
    check("run_busy_after_done", busy, 0);
    check("run_req_after_done", led_update_req, 0);
    check("run_step_after_done", start_calibration_step, 0);
  endtask

  initial begin : stimulus
    int unsigned n;
    // Reset state
    #12;
    check("reset_led_update_req", led_update_req, 0);
    check("reset_start_step", start_calibration_step, 0);
    check("reset_overwrite", should_overwrite_latch, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_bit_index", bit_index, 0);
    check("reset_seq_state", seq_state, SEQ_IDLE);
    @(negedge clk_pixel);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_pixel);

    // Randomized full runs with ignored stimulus sprinkled in
    spur_en = 1'b1;
    for (int r = 0; r < 6; r++) run_once();
    spur_en = 1'b0;
    repeat (25) @(negedge clk_pixel);

    // Abort during bit 1's step wait
    push_bits(0, 1);
    @(negedge clk_pixel);
    start = 1'b1;
    @(negedge clk_pixel);
    start = 1'b0;
    n = 0;
    while (!(start_calibration_step && bit_index == 1) && n < 500) begin
      @(negedge clk_pixel);
      n++;
    end
    check("abort_reached_bit1_step", bit_index, 1);
    n = 0;
    while (step_state == STEP_IDLE && n < 50) begin
      @(negedge clk_pixel);
      n++;
    end
    @(posedge clk_pixel);
    #1;
    check("abort_step_start_dropped", start_calibration_step, 0);
    check("abort_busy_before", busy, 1);
    check("abort_queue_consumed", exp_q.size(), 0);
    @(negedge clk_pixel);
    abort = 1'b1;
    @(posedge clk_pixel);
    #1;
    check("abort_busy", busy, 0);
    check("abort_bit_index", bit_index, 0);
    check("abort_req", led_update_req, 0);
    check("abort_step", start_calibration_step, 0);
    check("abort_overwrite", should_overwrite_latch, 0);
    check("abort_done", done, 0);
    check("abort_seq_state", seq_state, SEQ_IDLE);
    @(negedge clk_pixel);
    abort = 1'b0;
    repeat (30) @(negedge clk_pixel);
    run_once();

    // Asynchronous reset while STEP_START is held, start high through release
    step_en = 1'b0;
    push_bits(0, 0);
    @(negedge clk_pixel);
    start = 1'b1;
    @(negedge clk_pixel);
    start = 1'b0;
    n = 0;
    while (!start_calibration_step && n < 100) begin
      @(negedge clk_pixel);
      n++;
    end
    check("rst_reached_step_start", start_calibration_step, 1);
    @(negedge clk_pixel);
    #1;
    start = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_async_step", start_calibration_step, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_overwrite", should_overwrite_latch, 0);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk_pixel);
    check("rst_start_held_busy", busy, 0);
    check("rst_start_held_req", led_update_req, 0);
    check("rst_start_held_state", seq_state, SEQ_IDLE);
    start = 1'b0;
    step_en = 1'b1;
    repeat (3) @(negedge clk_pixel);
    run_once();

    // Withheld acknowledge: watchdog (when built in) or indefinite wait
    ack_en = 1'b0;
    push_bits(0, 0);
    exp_q.pop_back();
`ifdef CALIBRATION_SEQUENCER_TIMEOUT_EN
    exp_q.push_back('{EV_ERR, 0, 1'b0, 1'b0});
`endif
    @(negedge clk_pixel);
    start = 1'b1;
    @(posedge clk_pixel);
    #1;
    check("ack_hold_pattern_entry", led_update_req, 1);
    @(negedge clk_pixel);
    start = 1'b0;
    n = 0;
    while (!error && n < 150) begin
      @(posedge clk_pixel);
      #1;
      n++;
    end
`ifdef CALIBRATION_SEQUENCER_TIMEOUT_EN
    check("timeout_latency", n, TO);
    check("timeout_error", error, 1);
    check("timeout_busy", busy, 0);
    exp_q.push_back('{EV_REQ, 0, 1'b1, 1'b1});
    @(negedge clk_pixel);
    start = 1'b1;
    @(posedge clk_pixel);
    #1;
    check("timeout_cleared_by_start", error, 0);
    check("timeout_restart_req", led_update_req, 1);
    @(negedge clk_pixel);
    start = 1'b0;
`else
    check("no_timeout_error", error, 0);
    check("no_timeout_still_waiting", led_update_req, 1);
`endif
    @(negedge clk_pixel);
    abort = 1'b1;
    @(negedge clk_pixel);
    abort = 1'b0;
    check("final_abort_idle", seq_state, SEQ_IDLE);
    ack_en = 1'b1;
    repeat (5) @(negedge clk_pixel);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
